// File: rtl/instr_mem_pkg.sv
// Shared constants, FSM encoding and byte-placement helper for the instruction
// memory / program loader.
package instr_mem_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;
    localparam logic [31:0] PC_NONE   = 32'hFFFFFFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    // Little-endian placement of byte b into lane idx of word.
    function automatic logic [31:0] insert_byte(input logic [31:0] word,
                                                input logic [1:0]  idx,
                                                input logic [7:0]  b);
        logic [31:0] w;
        w = word;
        case (idx)
            2'd0:    w[7:0]   = b;
            2'd1:    w[15:8]  = b;
            2'd2:    w[23:16] = b;
            2'd3:    w[31:24] = b;
            default: w = word;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/instr_mem_if.sv
// Fetch port plus program-loader stream and status, shared by the core/loader
// (master) and the instruction memory (slave).
interface instr_mem_if;

    logic [31:0] instr_addr;
    logic [31:0] instr_data;
    logic [31:0] last_pc;
    logic        ld_start;
    logic        ld_valid;
    logic [7:0]  ld_byte;
    logic        ld_ready;
    logic        ld_done;
    logic        prog_ready;
    logic        load_err;
    logic [31:0] ld_csum;

    modport master (
        output instr_addr, ld_start, ld_valid, ld_byte, ld_done,
        input  instr_data, last_pc, ld_ready, prog_ready, load_err, ld_csum
    );

    modport slave (
        input  instr_addr, ld_start, ld_valid, ld_byte, ld_done,
        output instr_data, last_pc, ld_ready, prog_ready, load_err, ld_csum
    );

endinterface

// File: rtl/instr_mem_byte_asm.sv
// Byte-to-word assembler: collects little-endian bytes and presents the
// completed (or zero-padded, on flush) word combinationally with a valid pulse.
module byte_asm
    import instr_mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        accept,
    input  logic [7:0]  byte_in,
    input  logic        flush,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [1:0]  cnt_r;
    logic [31:0] acc_r;
    logic [31:0] next_acc_s;
    logic [1:0]  next_cnt_s;
    logic        full_s;
    logic        pad_s;

    // Merge the incoming byte; a flush emits any residue with zeros above it.
    always_comb begin
        next_acc_s = acc_r;
        next_cnt_s = cnt_r;
        full_s     = 1'b0;
        if (accept) begin
            next_acc_s = insert_byte(acc_r, cnt_r, byte_in);
            next_cnt_s = cnt_r + 2'd1;
            full_s     = (cnt_r == 2'd3);
        end else begin
            next_acc_s = acc_r;
            next_cnt_s = cnt_r;
            full_s     = 1'b0;
        end
        pad_s = flush && !full_s && (next_cnt_s != 2'd0);
    end

    assign word       = next_acc_s;
    assign word_valid = full_s || pad_s;

    // Accumulator is cleared after every emitted word so unused lanes read zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= 2'd0;
            acc_r <= 32'h0000_0000;
        end else if (clr || word_valid) begin
            cnt_r <= 2'd0;
            acc_r <= 32'h0000_0000;
        end else begin
            cnt_r <= next_cnt_s;
            acc_r <= next_acc_s;
        end
    end

endmodule

// File: rtl/instr_mem.sv
// Instruction memory with byte-stream program loader and 1-cycle fetch port.
// Define INSTR_MEM_CSUM_EN to build the ld_csum XOR accumulator (else ld_csum=0).
module instr_mem
    import instr_mem_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input logic         clk,
    input logic         rst_n,
    instr_mem_if.slave  bus
);

    localparam int              DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

    state_e            state_r;
    logic [ADDR_W:0]   word_cnt_r;
    logic [31:0]       last_pc_r;
    logic [31:0]       instr_data_r;
    logic              ld_ready_r;
    logic              prog_ready_r;
    logic              load_err_r;
    logic [31:0]       mem_r [DEPTH];

    logic              accept_s;
    logic              flush_s;
    logic [31:0]       asm_word_s;
    logic              asm_valid_s;
    logic              overflow_s;
    logic              wr_en_s;
    logic [ADDR_W:0]   cnt_next_s;
    logic [31:0]       last_pc_next_s;
    logic              rd_hit_s;

    // ld_start wins over any byte or ld_done offered in the same cycle.
    assign accept_s = bus.ld_valid && ld_ready_r && !bus.ld_start;
    assign flush_s  = bus.ld_done && (state_r == ST_LOAD) && !bus.ld_start;

    byte_asm u_byte_asm (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (bus.ld_start),
        .accept     (accept_s),
        .byte_in    (bus.ld_byte),
        .flush      (flush_s),
        .word       (asm_word_s),
        .word_valid (asm_valid_s)
    );

    assign overflow_s     = asm_valid_s && (word_cnt_r == FULL_CNT);
    assign wr_en_s        = asm_valid_s && !overflow_s;
    assign cnt_next_s     = word_cnt_r + {{ADDR_W{1'b0}}, wr_en_s};
    // Zero words wraps to all-ones, which is exactly PC_NONE.
    assign last_pc_next_s = 32'(cnt_next_s) - 32'd1;
    assign rd_hit_s       = (state_r == ST_RUN)
                         && (bus.instr_addr < 32'(word_cnt_r))
                         && (bus.instr_addr[31:ADDR_W] == '0);

    // Loader FSM with its registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            word_cnt_r   <= '0;
            last_pc_r    <= PC_NONE;
            ld_ready_r   <= 1'b0;
            prog_ready_r <= 1'b0;
            load_err_r   <= 1'b0;
        end else if (bus.ld_start) begin
            state_r      <= ST_LOAD;
            word_cnt_r   <= '0;
            last_pc_r    <= PC_NONE;
            ld_ready_r   <= 1'b1;
            prog_ready_r <= 1'b0;
            load_err_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_r    <= ST_IDLE;
                    ld_ready_r <= 1'b0;
                end
                ST_LOAD: begin
                    word_cnt_r <= cnt_next_s;
                    if (overflow_s) begin
                        load_err_r <= 1'b1;
                    end
                    if (bus.ld_done) begin
                        state_r      <= ST_RUN;
                        ld_ready_r   <= 1'b0;
                        prog_ready_r <= 1'b1;
                        last_pc_r    <= last_pc_next_s;
                    end
                end
                ST_RUN: begin
                    state_r    <= ST_RUN;
                    ld_ready_r <= 1'b0;
                end
                default: begin
                    state_r    <= ST_IDLE;
                    ld_ready_r <= 1'b0;
                end
            endcase
        end
    end

    // Program storage; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[word_cnt_r[ADDR_W-1:0]] <= asm_word_s;
        end
    end

    // Synchronous fetch: anything outside the loaded program reads as NOP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_data_r <= NOP_INSTR;
        end else if (rd_hit_s) begin
            instr_data_r <= mem_r[bus.instr_addr[ADDR_W-1:0]];
        end else begin
            instr_data_r <= NOP_INSTR;
        end
    end

`ifdef INSTR_MEM_CSUM_EN
    logic [31:0] csum_r;

    // Running XOR of every word actually written this load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_r <= 32'h0000_0000;
        end else if (bus.ld_start) begin
            csum_r <= 32'h0000_0000;
        end else if (wr_en_s) begin
            csum_r <= csum_r ^ asm_word_s;
        end else begin
            csum_r <= csum_r;
        end
    end

    assign bus.ld_csum = csum_r;
`else
    assign bus.ld_csum = 32'h0000_0000;
`endif

    assign bus.instr_data = instr_data_r;
    assign bus.last_pc    = last_pc_r;
    assign bus.ld_ready   = ld_ready_r;
    assign bus.prog_ready = prog_ready_r;
    assign bus.load_err   = load_err_r;

endmodule
